// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bundle: issue reservations, ALU/LSU result handshakes,
// decode busy queries and the registered register-file write port.
interface wb_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              issue_ready;

  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              lsu_valid;
  logic [4:0]        lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;

  logic              flush;

  logic [4:0]        chk_addr1;
  logic [4:0]        chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;

  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_ena;
  logic              err;

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  flush, chk_addr1, chk_addr2,
    output issue_ready, alu_ready, lsu_ready,
    output chk_busy1, chk_busy2,
    output w_addr, w_data, w_ena, err
  );

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output flush, chk_addr1, chk_addr2,
    input  issue_ready, alu_ready, lsu_ready,
    input  chk_busy1, chk_busy2,
    input  w_addr, w_data, w_ena, err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin ALU/LSU writeback arbiter with 32-entry busy scoreboard; accept -> write port
// registered one cycle later. Readies are combinational and drop during flush or reset.
module wb_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  wb_arbiter_if.slave io_wb
);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } result_t;

  logic [31:0]       r_busy;
  logic              r_last_alu;
  logic              r_w_ena;
  logic [4:0]        r_w_addr;
  logic [DATA_W-1:0] r_w_data;
  logic              r_err;

  logic              w_open;
  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_accept;
  logic              w_write;
  logic              w_issue_hs;
  result_t           w_sel;
  logic [31:0]       w_busy_nxt;

  assign w_open = i_rst && !io_wb.flush;

  assign io_wb.issue_ready = w_open && ((io_wb.issue_rd == 5'd0) || !r_busy[io_wb.issue_rd]);
  assign w_issue_hs        = io_wb.issue_valid && io_wb.issue_ready;

  // On a tie the source that did not win the previous acceptance is served.
  assign w_alu_gnt = w_open && io_wb.alu_valid && (!io_wb.lsu_valid || !r_last_alu);
  assign w_lsu_gnt = w_open && io_wb.lsu_valid && (!io_wb.alu_valid || r_last_alu);
  assign w_accept  = w_alu_gnt || w_lsu_gnt;

  assign io_wb.alu_ready = w_alu_gnt;
  assign io_wb.lsu_ready = w_lsu_gnt;

  always_comb begin
    w_sel.rd   = io_wb.lsu_rd;
    w_sel.data = io_wb.lsu_data;
    if (w_alu_gnt) begin
      w_sel.rd   = io_wb.alu_rd;
      w_sel.data = io_wb.alu_data;
    end
  end

  assign w_write = w_accept && (w_sel.rd != 5'd0);

  // Clear on the same edge the register file captures w_data, so busy never
  // drops before the value is readable.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_w_ena) begin
      w_busy_nxt[r_w_addr] = 1'b0;
    end
    if (io_wb.flush) begin
      w_busy_nxt = '0;
    end
    if (w_issue_hs) begin
      w_busy_nxt[io_wb.issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_busy     <= '0;
      r_last_alu <= 1'b1;
      r_w_ena    <= 1'b0;
      r_w_addr   <= 5'd0;
      r_w_data   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_w_ena <= w_write;
      if (w_write) begin
        r_w_addr <= w_sel.rd;
        r_w_data <= w_sel.data;
      end
      if (w_accept) begin
        r_last_alu <= w_alu_gnt;
      end
      if (w_write && !r_busy[w_sel.rd]) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_wb.chk_busy1 = r_busy[io_wb.chk_addr1];
  assign io_wb.chk_busy2 = r_busy[io_wb.chk_addr2];
  assign io_wb.w_ena     = r_w_ena;
  assign io_wb.w_addr    = r_w_addr;
  assign io_wb.w_data    = r_w_data;
  assign io_wb.err       = r_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, directed multi-cycle sequences and a
// randomized run, all cross-checked each cycle against a set-based reference model.
module tb_wb_arbiter;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DATA_W)) bus ();
  wb_arbiter #(.DATA_W(DATA_W)) dut (.i_clk(clk), .i_rst(rst), .io_wb(bus));

  int checks   = 0;
  int failures = 0;

  // Reference model: set of reserved registers, one pending commit, sticky error,
  // and which source is owed the next tie.
  bit        m_on = 1'b0;
  bit        m_busy [32];
  bit        m_wena;
  bit [4:0]  m_waddr;
  bit [63:0] m_wdata;
  bit        m_err;
  bit        m_alu_next;
  bit        e_alu, e_lsu;

  logic        o_iss, o_alu, o_lsu, o_b1, o_b2, o_wena, o_err;
  logic [4:0]  o_waddr;
  logic [63:0] o_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wena     = 1'b0;
    m_waddr    = 5'd0;
    m_wdata    = 64'd0;
    m_err      = 1'b0;
    m_alu_next = 1'b0;
  endtask

  // One clock: settle inputs, compare against the model, advance the model, take the edge.
  task automatic cyc();
    bit        open, e_iss, acc;
    bit [4:0]  ard;
    bit [63:0] adat;
    bit        nb [32];
    #2;
    open  = rst && !bus.flush;
    e_iss = open && (bus.issue_rd == 5'd0 || !m_busy[bus.issue_rd]);
    e_alu = open && bus.alu_valid && (!bus.lsu_valid || m_alu_next);
    e_lsu = open && bus.lsu_valid && !e_alu;
    o_iss = bus.issue_ready;  o_alu = bus.alu_ready;  o_lsu = bus.lsu_ready;
    o_b1  = bus.chk_busy1;    o_b2  = bus.chk_busy2;  o_wena = bus.w_ena;
    o_waddr = bus.w_addr;     o_wdata = bus.w_data;   o_err = bus.err;
    if (m_on) begin
      chk("mdl_issue_ready", o_iss, e_iss);
      chk("mdl_alu_ready", o_alu, e_alu);
      chk("mdl_lsu_ready", o_lsu, e_lsu);
      chk("mdl_chk_busy1", o_b1, m_busy[bus.chk_addr1]);
      chk("mdl_chk_busy2", o_b2, m_busy[bus.chk_addr2]);
      chk("mdl_w_ena", o_wena, m_wena);
      chk("mdl_w_addr", o_waddr, m_waddr);
      chk("mdl_w_data", o_wdata, m_wdata);
      chk("mdl_err", o_err, m_err);
    end
    if (!rst) begin
      model_reset();
      m_on = 1'b1;
    end else begin
      acc  = e_alu || e_lsu;
      ard  = e_alu ? bus.alu_rd : bus.lsu_rd;
      adat = e_alu ? bus.alu_data : bus.lsu_data;
      nb   = m_busy;
      if (m_wena) nb[m_waddr] = 1'b0;
      if (bus.flush) foreach (nb[i]) nb[i] = 1'b0;
      if (bus.issue_valid && e_iss && bus.issue_rd != 5'd0) nb[bus.issue_rd] = 1'b1;
      if (acc) begin
        if (ard != 5'd0 && !m_busy[ard]) m_err = 1'b1;
        m_alu_next = e_lsu;
      end
      m_wena = acc && ard != 5'd0;
      if (m_wena) begin
        m_waddr = ard;
        m_wdata = adat;
      end
      m_busy = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = '0;
    bus.flush = 1'b0; bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b0;
    for (int i = 0; i < n; i++) cyc();
    rst = 1'b1;
  endtask

  function automatic logic [4:0] pick_rd();
    int cand[$];
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    for (int i = 1; i < 32; i++) if (m_busy[i]) cand.push_back(i);
    if (cand.size() == 0) return 5'($urandom_range(0, 31));
    return 5'(cand[$urandom_range(0, cand.size() - 1)]);
  endfunction

  typedef struct {
    bit rst, flush, iv; bit [4:0] ird;
    bit av; bit [4:0] ard; bit [63:0] adat;
    bit lv; bit [4:0] lrd; bit [63:0] ldat;
    bit [4:0] c1;
    bit x_iss, x_alu, x_lsu, x_b1, x_wena; bit [4:0] x_waddr; bit [63:0] x_wdata; bit x_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int lq[$], aq[$], glog[$];
    int wena_cnt, first_w, last_w;

    tbl[0] = '{0,0,1,5, 1,5,64'h1, 1,6,64'h2, 5,  0,0,0,0,0,0,64'h0,0};
    tbl[1] = '{0,0,1,5, 1,5,64'h1, 1,6,64'h2, 5,  0,0,0,0,0,0,64'h0,0};
    tbl[2] = '{1,0,1,5, 0,0,64'h0, 0,0,64'h0, 5,  1,0,0,0,0,0,64'h0,0};
    tbl[3] = '{1,0,0,5, 1,5,64'hDEADBEEF, 0,0,64'h0, 5,  0,1,0,1,0,0,64'h0,0};
    tbl[4] = '{1,0,0,5, 0,0,64'h0, 0,0,64'h0, 5,  0,0,0,1,1,5,64'hDEADBEEF,0};
    tbl[5] = '{1,0,0,5, 0,0,64'h0, 0,0,64'h0, 5,  1,0,0,0,0,5,64'hDEADBEEF,0};
    tbl[6] = '{1,0,1,0, 0,0,64'h0, 1,0,64'h1234, 0,  1,0,1,0,0,5,64'hDEADBEEF,0};
    tbl[7] = '{1,0,0,0, 1,9,64'h99, 0,0,64'h0, 9,  1,1,0,0,0,5,64'hDEADBEEF,0};
    tbl[8] = '{1,0,0,0, 0,0,64'h0, 0,0,64'h0, 9,  1,0,0,0,1,9,64'h99,1};
    tbl[9] = '{1,0,0,0, 0,0,64'h0, 0,0,64'h0, 9,  1,0,0,0,0,9,64'h99,1};

    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc();

    // Vector table: reset, basic writeback, x0 result, unreserved write.
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; bus.flush = tbl[i].flush;
      bus.issue_valid = tbl[i].iv; bus.issue_rd = tbl[i].ird;
      bus.alu_valid = tbl[i].av; bus.alu_rd = tbl[i].ard; bus.alu_data = tbl[i].adat;
      bus.lsu_valid = tbl[i].lv; bus.lsu_rd = tbl[i].lrd; bus.lsu_data = tbl[i].ldat;
      bus.chk_addr1 = tbl[i].c1; bus.chk_addr2 = 5'd0;
      cyc();
      chk($sformatf("row%0d_issue_ready", i), o_iss, tbl[i].x_iss);
      chk($sformatf("row%0d_alu_ready", i), o_alu, tbl[i].x_alu);
      chk($sformatf("row%0d_lsu_ready", i), o_lsu, tbl[i].x_lsu);
      chk($sformatf("row%0d_chk_busy1", i), o_b1, tbl[i].x_b1);
      chk($sformatf("row%0d_w_ena", i), o_wena, tbl[i].x_wena);
      chk($sformatf("row%0d_w_addr", i), o_waddr, tbl[i].x_waddr);
      chk($sformatf("row%0d_w_data", i), o_wdata, tbl[i].x_wdata);
      chk($sformatf("row%0d_err", i), o_err, tbl[i].x_err);
    end

    // Contention: both sources continuously valid must alternate, LSU first.
    do_reset(2);
    for (int r = 1; r <= 8; r++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(r);
      cyc();
    end
    bus.issue_valid = 1'b0;
    lq = '{1, 2, 3, 4};
    aq = '{5, 6, 7, 8};
    wena_cnt = 0; first_w = -1; last_w = -1;
    for (int c = 0; c < 24; c++) begin
      bus.lsu_valid = (lq.size() > 0);
      bus.lsu_rd    = (lq.size() > 0) ? 5'(lq[0]) : 5'd0;
      bus.lsu_data  = 64'(100 + bus.lsu_rd);
      bus.alu_valid = (aq.size() > 0);
      bus.alu_rd    = (aq.size() > 0) ? 5'(aq[0]) : 5'd0;
      bus.alu_data  = 64'(200 + bus.alu_rd);
      cyc();
      if (o_wena === 1'b1) begin
        wena_cnt++;
        if (first_w < 0) first_w = c;
        last_w = c;
      end
      if (o_lsu === 1'b1 && lq.size() > 0) begin glog.push_back(0); void'(lq.pop_front()); end
      if (o_alu === 1'b1 && aq.size() > 0) begin glog.push_back(1); void'(aq.pop_front()); end
    end
    idle();
    chk("cont_grant_count", glog.size(), 8);
    for (int k = 0; k < glog.size() && k < 8; k++)
      chk($sformatf("cont_grant%0d_is_alu", k), glog[k], k % 2);
    chk("cont_wena_count", wena_cnt, 8);
    chk("cont_wena_span", last_w - first_w + 1, 8);
    for (int a = 0; a < 16; a++) begin
      bus.chk_addr1 = 5'(a); bus.chk_addr2 = 5'(a + 16);
      cyc();
      chk($sformatf("cont_clear_%0d", a), o_b1, 1'b0);
      chk($sformatf("cont_clear_%0d", a + 16), o_b2, 1'b0);
    end

    // WAW stall on rd 7, then x0 is always ready and never busy.
    do_reset(2);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.chk_addr1 = 5'd7;
    cyc();
    chk("waw_first_issue", o_iss, 1'b1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
    cyc();
    chk("waw_stall_accept", o_iss, 1'b0);
    chk("waw_alu_accept", o_alu, 1'b1);
    bus.alu_valid = 1'b0;
    cyc();
    chk("waw_stall_wena", o_iss, 1'b0);
    chk("waw_wena", o_wena, 1'b1);
    chk("waw_busy_during_wena", o_b1, 1'b1);
    cyc();
    chk("waw_release", o_iss, 1'b1);
    chk("waw_busy_clear", o_b1, 1'b0);
    bus.issue_rd = 5'd0; bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd7;
    cyc();
    chk("x0_ready", o_iss, 1'b1);
    chk("x0_busy", o_b1, 1'b0);
    chk("waw_rebusy", o_b2, 1'b1);
    idle();

    // Flush with a write pending for rd 3 and a reservation on rd 4.
    do_reset(2);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; cyc();
    bus.issue_rd = 5'd4; cyc();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h33;
    cyc();
    chk("fl_pre_accept", o_alu, 1'b1);
    bus.flush = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 64'h44;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
    bus.chk_addr1 = 5'd3; bus.chk_addr2 = 5'd4;
    cyc();
    chk("fl_alu_ready", o_alu, 1'b0);
    chk("fl_issue_ready", o_iss, 1'b0);
    chk("fl_wena", o_wena, 1'b1);
    chk("fl_waddr", o_waddr, 5'd3);
    chk("fl_busy4_before", o_b2, 1'b1);
    bus.flush = 1'b0; bus.issue_valid = 1'b0;
    cyc();
    chk("fl_busy3_after", o_b1, 1'b0);
    chk("fl_busy4_after", o_b2, 1'b0);
    chk("fl_late_accept", o_alu, 1'b1);
    chk("fl_err_before", o_err, 1'b0);
    bus.alu_valid = 1'b0; bus.chk_addr2 = 5'd11;
    cyc();
    chk("fl_err_after", o_err, 1'b1);
    chk("fl_late_write", o_waddr, 5'd4);
    chk("fl_no_reserve", o_b2, 1'b0);

    // Randomized traffic; sources hold their offer until the model says accepted.
    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      if (!bus.alu_valid && $urandom_range(0, 2) == 0) begin
        bus.alu_valid = 1'b1; bus.alu_rd = pick_rd(); bus.alu_data = {$urandom, $urandom};
      end
      if (!bus.lsu_valid && $urandom_range(0, 2) == 0) begin
        bus.lsu_valid = 1'b1; bus.lsu_rd = pick_rd(); bus.lsu_data = {$urandom, $urandom};
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 31));
      bus.flush       = ($urandom_range(0, 39) == 0);
      rst             = ($urandom_range(0, 199) != 0);
      bus.chk_addr1   = 5'($urandom_range(0, 31));
      bus.chk_addr2   = 5'($urandom_range(0, 31));
      cyc();
      if (e_alu) bus.alu_valid = 1'b0;
      if (e_lsu) bus.lsu_valid = 1'b0;
    end
    rst = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
